bp_update_queue: RTL and testbench
==================================

# bp_update_queue

In-order update queue that drives the write side of the local history table. Dispatch enqueues every conditional branch with the LHT index and the 2-bit state predicted at decode. The branch unit resolves entries out of order by tag. The queue drains resolved entries from the head, one per cycle, into the LHT write port, and forwards the most recent write so that back-to-back updates to one index do not use a stale state.

## Interface
Parameters:
- QUEUE_DEPTH, default 8: number of entries; power of two, ≥2.
- LHT_DEPTH, from rv32i_types: number of LHT entries; sets the index width IW = $clog2(LHT_DEPTH).
- TW = $clog2(QUEUE_DEPTH): tag width.

Ports (all single clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- enq_valid  in  1  dispatch has a branch to enqueue
- enq_ready  out  1  queue can accept an entry
- enq_idx  in  IW  LHT index of the branch
- enq_state  in  bp_state_t  state read from the LHT at decode
- enq_tag  out  TW  tag of the entry allocated by this handshake
- res_valid  in  1  branch unit resolves one entry
- res_tag  in  TW  tag being resolved
- res_taken  in  1  actual branch outcome
- res_mispredict  out  1  combinational: res_valid, entry valid and unresolved, and predicted direction ≠ res_taken
- flush  in  1  pipeline flush; discards all entries
- branch_we  out  1  LHT write enable
- write_idx  out  IW  LHT write index
- branch_taken  out  1  outcome being written
- bp_prev_state  out  bp_state_t  prior state for the LHT next-state computation
- count  out  TW+1  number of occupied entries

## Operation
- Storage is a circular buffer of QUEUE_DEPTH entries. Each entry holds {valid, resolved, idx, state, taken}.
- Pointers are head and tail, each TW bits, wrapping modulo QUEUE_DEPTH.
- Enqueue:
  - The handshake is enq_valid && enq_ready.
  - enq_ready = (count < QUEUE_DEPTH). It does not depend on a same-cycle pop.
  - enq_tag = tail.
  - The entry at tail is written with valid=1, resolved=0, idx=enq_idx, state=enq_state, and tail increments.
- Predicted direction is taken when the state is wt or st, and not taken when it is snt or wnt.
- Resolve:
  - Applies when res_valid is high and the entry at res_tag is valid and unresolved.
  - The entry is updated with resolved=1 and taken=res_taken.
  - Otherwise the request is ignored, with no state change and res_mispredict=0.
- Drain:
  - Fires when the head entry is valid and resolved and flush is low.
  - branch_we=1, write_idx=head.idx, branch_taken=head.taken.
  - The head entry is cleared and head increments at the next edge.
  - At most one entry drains per cycle, strictly in program order. An unresolved head blocks all younger entries.
- Forwarding:
  - Registers last_we, last_idx and last_next capture the state of each drain.
  - last_next is the saturating-counter next state: snt→{snt,wnt}, wnt→{snt,wt}, wt→{wnt,st}, st→{wt,st}. The first element of each pair applies for not-taken, the second for taken.
  - When last_we=1 and last_idx == head.idx, bp_prev_state = last_next. Otherwise bp_prev_state = head.state.
  - Forwarding covers a one-cycle distance only.
- Flush:
  - At the next edge, all valid bits clear, head = tail = 0, count = 0 and last_we = 0.
  - In the flush cycle, branch_we=0; any enqueue and resolve in that cycle are dropped.
- count is the registered occupancy. It is +1 on enqueue, −1 on drain, and unchanged when both happen in the same cycle.

## Timing
- Reset values:
  - Outputs: branch_we=0, write_idx=0, branch_taken=0, bp_prev_state=wnt, enq_ready=1, enq_tag=0, count=0, res_mispredict=0.
  - Internal: all valid bits 0, head=tail=0, last_we=0.
- When the head is empty, write_idx, branch_taken and bp_prev_state hold their reset values.
- Reset in mid-operation behaves the same as flush and has priority over every other input.
- Enqueue in cycle N: the entry can be resolved from cycle N+1.
- Resolve in cycle N: the earliest drain is cycle N+1, with branch_we high combinationally from registered state.
- Minimum enqueue-to-drain latency is 2 cycles.
- Sustained throughput is one drain per cycle.
- Full queue: enq_ready=0 even if a drain happens in the same cycle. enq_ready rises the cycle after the drain.
- A resolve and a drain in the same cycle cannot target the same entry, because drain requires resolved=1.
- Tags are reused after wrap. A stale tag that hits a newer, unresolved entry is an upstream error and is not checked.

## Test plan
- **Reset and simple update.** After reset, enqueue idx=5, state=wnt. Resolve tag 0 taken in cycle 2. Required: res_mispredict=1; in cycle 3, branch_we=1, write_idx=5, branch_taken=1, bp_prev_state=wnt; count returns to 0.
- **Out-of-order resolve.** Enqueue tags 0,1,2. Resolve 2, then 1, then 0 on consecutive cycles. Required: no branch_we until tag 0 is resolved, then drains of 0,1,2 on three consecutive cycles.
- **Forwarding.** Enqueue two entries, both idx=3, state=wt, and resolve both not-taken. Required: first drain bp_prev_state=wt; second drain bp_prev_state=wnt (forwarded).
- **Full and wrap.** Enqueue 8 entries. Required: enq_ready=0 and count=8. Resolve and drain one. Required: enq_ready=1 the next cycle, and the next enq_tag=0.
- **Flush.** Flush with 4 entries, 2 of them resolved. Required: no branch_we in the flush cycle or after; count=0; the next enq_tag=0.
- **Ignored resolves.** Resolve an empty tag, and resolve an already-resolved tag with the opposite outcome. Required: no state change and res_mispredict=0; the original outcome is the one written.

Source files
------------

// File: rtl/bp_update_queue.sv
// In-order LHT update queue: entries are enqueued at dispatch, resolved out of
// order by tag, and drained from the head into the LHT write port with one-cycle forwarding.
module bp_update_queue #(
    parameter int QUEUE_DEPTH = 8,
    parameter int LHT_DEPTH   = 64,
    localparam int TW = $clog2(QUEUE_DEPTH),
    localparam int IW = $clog2(LHT_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enq_valid,
    output logic          enq_ready,
    input  logic [IW-1:0] enq_idx,
    input  logic [1:0]    enq_state,
    output logic [TW-1:0] enq_tag,
    input  logic          res_valid,
    input  logic [TW-1:0] res_tag,
    input  logic          res_taken,
    output logic          res_mispredict,
    input  logic          flush,
    output logic          branch_we,
    output logic [IW-1:0] write_idx,
    output logic          branch_taken,
    output logic [1:0]    bp_prev_state,
    output logic [TW:0]   count
);

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    logic [QUEUE_DEPTH-1:0] entry_valid;
    logic [QUEUE_DEPTH-1:0] entry_resolved;
    logic [QUEUE_DEPTH-1:0] entry_taken;
    logic [IW-1:0]          entry_idx   [QUEUE_DEPTH];
    logic [1:0]             entry_state [QUEUE_DEPTH];

    logic [TW-1:0] head;
    logic [TW-1:0] tail;
    logic          last_we;
    logic [IW-1:0] last_idx;
    logic [1:0]    last_next;

    logic head_valid;
    logic drain;
    logic res_hit;
    logic accept;

    function automatic logic [1:0] next_state(input logic [1:0] s, input logic t);
        case (s)
            SNT:     return t ? WNT : SNT;
            WNT:     return t ? WT  : SNT;
            WT:      return t ? ST  : WNT;
            default: return t ? ST  : WT;
        endcase
    endfunction

    assign enq_ready  = (count < (TW+1)'(QUEUE_DEPTH));
    assign enq_tag    = tail;
    assign accept     = enq_valid && enq_ready;
    assign head_valid = entry_valid[head];
    assign drain      = head_valid && entry_resolved[head] && !flush && !rst;
    assign res_hit    = res_valid && entry_valid[res_tag] && !entry_resolved[res_tag];

    // Predicted direction is the MSB of the two-bit counter (wt/st are taken).
    assign res_mispredict = res_hit && (entry_state[res_tag][1] != res_taken);

    assign branch_we    = drain;
    assign write_idx    = head_valid ? entry_idx[head] : '0;
    assign branch_taken = head_valid ? entry_taken[head] : 1'b0;

    // The previous drain's write may not be visible in the LHT yet, so its result wins on an index match.
    always_comb begin
        bp_prev_state = WNT;
        if (head_valid) begin
            if (last_we && (last_idx == entry_idx[head]))
                bp_prev_state = last_next;
            else
                bp_prev_state = entry_state[head];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            entry_valid    <= '0;
            entry_resolved <= '0;
            entry_taken    <= '0;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            last_we        <= 1'b0;
            last_idx       <= '0;
            last_next      <= WNT;
        end else begin
            last_we <= drain;
            if (drain) begin
                last_idx  <= entry_idx[head];
                last_next <= next_state(bp_prev_state, branch_taken);
            end
            if (res_hit) begin
                entry_resolved[res_tag] <= 1'b1;
                entry_taken[res_tag]    <= res_taken;
            end
            if (drain) begin
                entry_valid[head]    <= 1'b0;
                entry_resolved[head] <= 1'b0;
                head                 <= head + TW'(1);
            end
            // A full queue never accepts, so tail cannot collide with the draining head.
            if (accept) begin
                entry_valid[tail]    <= 1'b1;
                entry_resolved[tail] <= 1'b0;
                entry_taken[tail]    <= 1'b0;
                entry_idx[tail]      <= enq_idx;
                entry_state[tail]    <= enq_state;
                tail                 <= tail + TW'(1);
            end
            case ({accept, drain})
                2'b10:   count <= count + (TW+1)'(1);
                2'b01:   count <= count - (TW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_update_queue.sv
// Self-checking bench for bp_update_queue: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of the update queue.
module tb_bp_update_queue;

    localparam int DEPTH = 8;
    localparam int IW    = 6;
    localparam int TW    = 3;
    localparam int SNT = 0, WNT = 1, WT = 2, ST = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          enq_valid;
    logic          enq_ready;
    logic [IW-1:0] enq_idx;
    logic [1:0]    enq_state;
    logic [TW-1:0] enq_tag;
    logic          res_valid;
    logic [TW-1:0] res_tag;
    logic          res_taken;
    logic          res_mispredict;
    logic          flush;
    logic          branch_we;
    logic [IW-1:0] write_idx;
    logic          branch_taken;
    logic [1:0]    bp_prev_state;
    logic [TW:0]   count;

    bp_update_queue #(.QUEUE_DEPTH(DEPTH), .LHT_DEPTH(64)) dut (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_idx(enq_idx),
        .enq_state(enq_state), .enq_tag(enq_tag),
        .res_valid(res_valid), .res_tag(res_tag), .res_taken(res_taken),
        .res_mispredict(res_mispredict), .flush(flush),
        .branch_we(branch_we), .write_idx(write_idx), .branch_taken(branch_taken),
        .bp_prev_state(bp_prev_state), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tag;
        int idx;
        int state;
        bit resolved;
        bit taken;
    } ent_t;

    ent_t mq[$];
    int   tail_tag;
    bit   m_last_we;
    int   m_last_idx;
    int   m_last_next;
    int   tests_run = 0;
    int   tests_failed = 0;

    function automatic int sat_next(input int s, input bit t);
        if (t) return (s < 3) ? s + 1 : 3;
        return (s > 0) ? s - 1 : 0;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        tail_tag  = 0;
        m_last_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enq_valid = 1'b1; enq_idx = 6'd9; enq_state = 2'd3;
        res_valid = 1'b1; res_tag = '0; res_taken = 1'b1; flush = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic apply_stimulus(input bit ev, input int eidx, input int est,
                                  input bit rv, input int rtag, input bit rtk, input bit fl);
        int  cnt;
        bit  exp_misp;
        bit  drained;
        int  exp_prev;
        enq_valid = ev;  enq_idx = IW'(eidx); enq_state = 2'(est);
        res_valid = rv;  res_tag = TW'(rtag); res_taken = rtk; flush = fl;
        @(negedge clk);

        cnt = mq.size();
        exp_misp = 1'b0;
        foreach (mq[i])
            if (rv && mq[i].tag == rtag && !mq[i].resolved)
                exp_misp = ((mq[i].state >= WT) != rtk);
        drained  = (cnt > 0) && mq[0].resolved && !fl;
        exp_prev = WNT;
        if (cnt > 0)
            exp_prev = (m_last_we && m_last_idx == mq[0].idx) ? m_last_next : mq[0].state;

        check_output("count", 32'(count), 32'(cnt));
        check_output("enq_ready", 32'(enq_ready), 32'(cnt < DEPTH));
        check_output("enq_tag", 32'(enq_tag), 32'(tail_tag));
        check_output("res_mispredict", 32'(res_mispredict), 32'(exp_misp));
        check_output("branch_we", 32'(branch_we), 32'(drained));
        check_output("write_idx", 32'(write_idx), 32'((cnt > 0) ? mq[0].idx : 0));
        check_output("branch_taken", 32'(branch_taken),
                     32'((cnt > 0) ? (mq[0].resolved && mq[0].taken) : 1'b0));
        check_output("bp_prev_state", 32'(bp_prev_state), 32'(exp_prev));

        if (fl) begin
            model_clear();
        end else begin
            if (drained) begin
                m_last_idx  = mq[0].idx;
                m_last_next = sat_next(exp_prev, mq[0].taken);
            end
            m_last_we = drained;
            if (rv)
                foreach (mq[i])
                    if (mq[i].tag == rtag && !mq[i].resolved) begin
                        mq[i].resolved = 1'b1;
                        mq[i].taken    = rtk;
                    end
            if (drained) void'(mq.pop_front());
            if (ev && cnt < DEPTH) begin
                mq.push_back('{tag: tail_tag, idx: eidx, state: est, resolved: 1'b0, taken: 1'b0});
                tail_tag = (tail_tag + 1) % DEPTH;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; enq_valid = 0; enq_idx = '0; enq_state = '0;
        res_valid = 0; res_tag = '0; res_taken = 0; flush = 0;
        @(posedge clk);
        #1;
        do_reset();
        idle();

        // Simple update: enqueue idx 5 wnt, resolve taken, drain.
        apply_stimulus(1, 5, WNT, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 1, 0, 1, 0);
        idle();
        idle();

        // Out-of-order resolve.
        do_reset();
        apply_stimulus(1, 1, ST, 0, 0, 0, 0);
        apply_stimulus(1, 2, SNT, 0, 0, 0, 0);
        apply_stimulus(1, 3, WT, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 1, 2, 1, 0);
        apply_stimulus(0, 0, 0, 1, 1, 0, 0);
        apply_stimulus(0, 0, 0, 1, 0, 1, 0);
        repeat (4) idle();

        // Forwarding on back-to-back drains to one index.
        do_reset();
        apply_stimulus(1, 3, WT, 0, 0, 0, 0);
        apply_stimulus(1, 3, WT, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 1, 0, 0, 0);
        apply_stimulus(0, 0, 0, 1, 1, 0, 0);
        repeat (3) idle();

        // Full queue and tag wrap.
        do_reset();
        for (int i = 0; i < DEPTH; i++) apply_stimulus(1, i, i % 4, 0, 0, 0, 0);
        apply_stimulus(1, 9, ST, 1, 0, 1, 0);
        apply_stimulus(1, 10, ST, 0, 0, 0, 0);
        apply_stimulus(1, 11, SNT, 0, 0, 0, 0);
        idle();

        // Flush with partially resolved entries.
        do_reset();
        for (int i = 0; i < 4; i++) apply_stimulus(1, 20 + i, WT, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 1, 1, 1, 0);
        apply_stimulus(0, 0, 0, 1, 3, 0, 0);
        apply_stimulus(1, 30, ST, 1, 0, 1, 1);
        idle();
        apply_stimulus(1, 31, SNT, 0, 0, 0, 0);
        idle();

        // Ignored resolves: empty tag, then an already-resolved tag.
        do_reset();
        apply_stimulus(0, 0, 0, 1, 4, 1, 0);
        apply_stimulus(1, 7, ST, 0, 0, 0, 0);
        apply_stimulus(1, 7, SNT, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 1, 1, 1, 0);
        apply_stimulus(0, 0, 0, 1, 1, 0, 0);
        apply_stimulus(0, 0, 0, 1, 0, 0, 0);
        apply_stimulus(0, 0, 0, 1, 0, 1, 0);
        repeat (3) idle();

        // Random traffic with a mid-run reset.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bit ev, rv, rtk, fl;
            int rtag;
            if (n == 1500) do_reset();
            ev  = ($urandom_range(99) < 60);
            rv  = ($urandom_range(99) < 70);
            rtk = $urandom_range(1);
            fl  = ($urandom_range(99) < 2);
            if (mq.size() > 0 && $urandom_range(99) < 75)
                rtag = mq[$urandom_range(mq.size() - 1)].tag;
            else
                rtag = $urandom_range(DEPTH - 1);
            apply_stimulus(ev, $urandom_range(3), $urandom_range(3), rv, rtag, rtk, fl);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
